// File: rtl/centroid_pkg.sv
// rtl/centroid_pkg.sv - shared FSM state type and default geometry/width constants for centroid_tracker
package centroid_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVIDE  = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_SUM_W    = 32;
    localparam int DEF_CNT_W    = 20;

endpackage

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - unsigned restoring divider, one quotient bit per cycle, W iterations
module iter_divider #(
    parameter int W     = 32,
    parameter int OUT_W = W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     dividend,
    input  logic [W-1:0]     divisor,
    output logic [OUT_W-1:0] quotient,
    output logic             done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dsor;
    logic [CW-1:0] remaining;
    logic          running;
    logic [W:0]    shifted;
    logic [W:0]    trial;

    // The dividend shifts out of quo MSB-first while quotient bits shift in at the bottom.
    // A borrow in trial[W] means the shifted remainder is below the divisor.
    always_comb begin
        shifted = {rem, quo[W-1]};
        trial   = shifted - {1'b0, dsor};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem       <= '0;
            quo       <= '0;
            dsor      <= '0;
            remaining <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else if (start) begin
            rem       <= '0;
            quo       <= dividend;
            dsor      <= divisor;
            remaining <= CW'(W);
            running   <= 1'b1;
            done      <= 1'b0;
        end else if (running) begin
            if (!trial[W]) begin
                rem <= trial[W-1:0];
                quo <= {quo[W-2:0], 1'b1};
            end else begin
                rem <= shifted[W-1:0];
                quo <= {quo[W-2:0], 1'b0};
            end
            remaining <= remaining - 1'b1;
            if (remaining == CW'(1)) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    assign quotient = quo[OUT_W-1:0];

endmodule

// File: rtl/centroid_tracker.sv
// rtl/centroid_tracker.sv - mask-pixel centroid per frame with optional crosshair overlay (CENTROID_CROSSHAIR_EN)
module centroid_tracker
    import centroid_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int SUM_W      = DEF_SUM_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MIN_PIXELS = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        valid_in,
    input  logic        mask_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        busy_out,
    output logic        dropped_out,
    output logic        crosshair_out
);

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

    state_t state, state_next;

    logic             pix_hit;
    logic             eof;
    logic             eof_q;
    logic             div_start;
    logic [SUM_W-1:0] x_sum, y_sum, x_next, y_next;
    logic [SUM_W-1:0] x_snap, y_snap;
    logic [CNT_W-1:0] count, count_next, count_snap;
    logic [10:0]      x_quo;
    logic [9:0]       y_quo;
    logic             x_done, y_done;

    assign pix_hit = valid_in && mask_in;
    assign eof     = valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);

    always_comb begin
        x_next     = x_sum + (pix_hit ? SUM_W'(hcount_in) : '0);
        y_next     = y_sum + (pix_hit ? SUM_W'(vcount_in) : '0);
        count_next = (pix_hit && (count != '1)) ? count + 1'b1 : count;
    end

    // Live accumulators restart every frame regardless of divider state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_sum <= '0;
            y_sum <= '0;
            count <= '0;
        end else if (eof) begin
            x_sum <= '0;
            y_sum <= '0;
            count <= '0;
        end else begin
            x_sum <= x_next;
            y_sum <= y_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_snap      <= '0;
            y_snap      <= '0;
            count_snap  <= '0;
            eof_q       <= 1'b0;
            dropped_out <= 1'b0;
        end else begin
            eof_q <= eof && (state == IDLE);
            if (eof && (state == IDLE)) begin
                x_snap     <= x_next;
                y_snap     <= y_next;
                count_snap <= count_next;
            end
            if (eof && (state != IDLE)) begin
                dropped_out <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        case (state)
            IDLE: begin
                if (eof_q && (count_snap >= CNT_W'(MIN_PIXELS))) begin
                    state_next = DIVIDE;
                    div_start  = 1'b1;
                end
            end
            DIVIDE: begin
                if (x_done && y_done) begin
                    state_next = PUBLISH;
                end
            end
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    iter_divider #(.W(SUM_W), .OUT_W(11)) u_x_div (
        .clk      (clk_in),
        .rst      (rst_in),
        .start    (div_start),
        .dividend (x_snap),
        .divisor  (SUM_W'(count_snap)),
        .quotient (x_quo),
        .done     (x_done)
    );

    iter_divider #(.W(SUM_W), .OUT_W(10)) u_y_div (
        .clk      (clk_in),
        .rst      (rst_in),
        .start    (div_start),
        .dividend (y_snap),
        .divisor  (SUM_W'(count_snap)),
        .quotient (y_quo),
        .done     (y_done)
    );

    // Results load on the edge that enters PUBLISH, so valid_out and the new values appear together.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_out <= '0;
            y_out <= '0;
        end else if ((state == DIVIDE) && x_done && y_done) begin
            x_out <= x_quo;
            y_out <= y_quo;
        end
    end

    assign valid_out = (state == PUBLISH);
    assign busy_out  = (state == DIVIDE);

`ifdef CENTROID_CROSSHAIR_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            crosshair_out <= 1'b0;
        end else begin
            crosshair_out <= valid_in && ((hcount_in == x_out) || (vcount_in == y_out));
        end
    end
`else
    assign crosshair_out = 1'b0;
`endif

endmodule

// File: tb/tb_centroid_tracker.sv
// tb/tb_centroid_tracker.sv - randomized self-checking bench for centroid_tracker against a frame-level model
module tb_centroid_tracker;

    localparam int SUM_W   = 32;
    localparam int LATENCY = SUM_W + 2;
    localparam int MIN_PIX = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        valid_in, mask_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out, busy_out, dropped_out, crosshair_out;

    logic [10:0] hc2;
    logic [9:0]  vc2;
    logic        val2, mask2;
    logic [10:0] x2;
    logic [9:0]  y2;
    logic        valid2, busy2, drop2, cross2;

    always #5 clk_in = ~clk_in;

    centroid_tracker u_dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .valid_in      (valid_in),
        .mask_in       (mask_in),
        .x_out         (x_out),
        .y_out         (y_out),
        .valid_out     (valid_out),
        .busy_out      (busy_out),
        .dropped_out   (dropped_out),
        .crosshair_out (crosshair_out)
    );

    centroid_tracker #(.H_ACTIVE(8), .V_ACTIVE(4)) u_short (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .hcount_in     (hc2),
        .vcount_in     (vc2),
        .valid_in      (val2),
        .mask_in       (mask2),
        .x_out         (x2),
        .y_out         (y2),
        .valid_out     (valid2),
        .busy_out      (busy2),
        .dropped_out   (drop2),
        .crosshair_out (cross2)
    );

    typedef struct {
        int h;
        int v;
    } pix_t;

    pix_t frame_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_x, exp_y, exp_cnt;
    int   pub_x = 0;
    int   pub_y = 0;

    function void model_frame(input bit eof_mask);
        longint xs, ys;
        xs = 0;
        ys = 0;
        exp_cnt = 0;
        foreach (frame_q[i]) begin
            xs += frame_q[i].h;
            ys += frame_q[i].v;
            exp_cnt++;
        end
        if (eof_mask) begin
            xs += 1023;
            ys += 767;
            exp_cnt++;
        end
        if (exp_cnt >= MIN_PIX) begin
            exp_x = int'(xs / exp_cnt);
            exp_y = int'(ys / exp_cnt);
        end else begin
            exp_x = pub_x;
            exp_y = pub_y;
        end
    endfunction

    task automatic drive(input bit v, input int h, input int vv, input bit m);
        valid_in  = v;
        hcount_in = 11'(h);
        vcount_in = 10'(vv);
        mask_in   = m;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input bit eof_mask);
        foreach (frame_q[i]) drive(1'b1, frame_q[i].h, frame_q[i].v, 1'b1);
        drive(1'b1, 1023, 767, eof_mask);
        valid_in = 1'b0;
        mask_in  = 1'b0;
    endtask

    task automatic wait_result(output int lat, output bit busy_first);
        lat        = 201;
        busy_first = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk_in);
            #1;
            if (k == 1) busy_first = busy_out;
            if (valid_out) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input int lat);
        n_cmp++;
        if (lat != LATENCY) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, LATENCY);
        end
        n_cmp++;
        if (x_out !== 11'(exp_x) || y_out !== 10'(exp_y)) begin
            n_fail++;
            $display("FAIL %s xy: got (%0d,%0d) expected (%0d,%0d)", name, x_out, y_out, exp_x, exp_y);
        end
        pub_x = exp_x;
        pub_y = exp_y;
    endtask

    task automatic fill_block();
        frame_q.delete();
        for (int v = 200; v <= 203; v++)
            for (int h = 100; h <= 103; h++) frame_q.push_back('{h: h, v: v});
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        valid_in = 1'b0; mask_in = 1'b0; hcount_in = '0; vcount_in = '0;
        val2 = 1'b0; mask2 = 1'b0; hc2 = '0; vc2 = '0;
        repeat (3) @(posedge clk_in);
        #1;
        n_cmp++;
        if ({x_out, y_out, valid_out, busy_out, dropped_out, crosshair_out} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got x=%0d y=%0d v=%0b b=%0b d=%0b c=%0b expected all 0",
                     x_out, y_out, valid_out, busy_out, dropped_out, crosshair_out);
        end
        rst_in = 1'b0;
        pub_x = 0;
        pub_y = 0;
    endtask

    task automatic test_single_block();
        int lat;
        bit bf;
        fill_block();
        model_frame(1'b0);
        send_frame(1'b0);
        wait_result(lat, bf);
        n_cmp++;
        if (bf !== 1'b1) begin
            n_fail++;
            $display("FAIL block busy_at_start: got %0b expected 1", bf);
        end
        check_result("block", lat);
        @(posedge clk_in);
        #1;
        n_cmp++;
        if (valid_out !== 1'b0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL block after_pulse: got v=%0b b=%0b expected 0 0", valid_out, busy_out);
        end
    endtask

    task automatic test_crosshair();
        int h, v, sel;
        bit vld, exp_c;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            h   = (sel == 0 || sel == 3) ? pub_x : $urandom_range(0, 1022);
            v   = (sel == 1 || sel == 3) ? pub_y : $urandom_range(0, 766);
            vld = ($urandom_range(0, 4) != 0);
            drive(vld, h, v, 1'b0);
`ifdef CENTROID_CROSSHAIR_EN
            exp_c = vld && (h == pub_x || v == pub_y);
`else
            exp_c = 1'b0;
`endif
            n_cmp++;
            if (crosshair_out !== exp_c) begin
                n_fail++;
                $display("FAIL crosshair h=%0d v=%0d vld=%0b: got %0b expected %0b", h, v, vld, crosshair_out, exp_c);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_below_threshold();
        int seen_valid, seen_busy;
        frame_q.delete();
        for (int i = 0; i < 10; i++) frame_q.push_back('{h: $urandom_range(0, 1022), v: $urandom_range(0, 766)});
        model_frame(1'b0);
        send_frame(1'b0);
        seen_valid = 0;
        seen_busy  = 0;
        repeat (60) begin
            @(posedge clk_in);
            #1;
            if (valid_out) seen_valid++;
            if (busy_out) seen_busy++;
        end
        n_cmp++;
        if (seen_valid != 0 || seen_busy != 0) begin
            n_fail++;
            $display("FAIL below_thresh activity: got valid=%0d busy=%0d cycles expected 0 0", seen_valid, seen_busy);
        end
        n_cmp++;
        if (x_out !== 11'(pub_x) || y_out !== 10'(pub_y)) begin
            n_fail++;
            $display("FAIL below_thresh hold: got (%0d,%0d) expected (%0d,%0d)", x_out, y_out, pub_x, pub_y);
        end
    endtask

    task automatic test_last_pixel();
        int lat;
        bit bf;
        frame_q.delete();
        for (int i = 0; i < 15; i++) frame_q.push_back('{h: 1023, v: 0});
        model_frame(1'b1);
        send_frame(1'b1);
        wait_result(lat, bf);
        check_result("last_pixel", lat);
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_random_frames();
        int lat, n;
        bit bf, em;
        for (int f = 0; f < 5; f++) begin
            frame_q.delete();
            n = $urandom_range(16, 70);
            for (int i = 0; i < n; i++) frame_q.push_back('{h: $urandom_range(0, 1022), v: $urandom_range(0, 766)});
            em = 1'($urandom_range(0, 1));
            model_frame(em);
            send_frame(em);
            wait_result(lat, bf);
            check_result("random", lat);
            repeat ($urandom_range(1, 5)) @(posedge clk_in);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        int seen_valid, lat;
        bit bf;
        frame_q.delete();
        for (int i = 0; i < 20; i++) frame_q.push_back('{h: $urandom_range(0, 1022), v: $urandom_range(0, 766)});
        send_frame(1'b1);
        repeat (10) @(posedge clk_in);
        #1;
        n_cmp++;
        if (busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid busy_before: got %0b expected 1", busy_out);
        end
        rst_in = 1'b1;
        #1;
        n_cmp++;
        if ({x_out, y_out, valid_out, busy_out, dropped_out} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got x=%0d y=%0d v=%0b b=%0b d=%0b expected all 0",
                     x_out, y_out, valid_out, busy_out, dropped_out);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        pub_x = 0;
        pub_y = 0;
        seen_valid = 0;
        repeat (60) begin
            @(posedge clk_in);
            #1;
            if (valid_out) seen_valid++;
        end
        n_cmp++;
        if (seen_valid != 0) begin
            n_fail++;
            $display("FAIL reset_mid stray_valid: got %0d pulses expected 0", seen_valid);
        end
        fill_block();
        model_frame(1'b0);
        send_frame(1'b0);
        wait_result(lat, bf);
        check_result("after_reset", lat);
    endtask

    task automatic test_dropped();
        longint xs, ys;
        int cnt, t, t_eof1, pt, px, py, pulses;
        bit m;
        xs = 0; ys = 0; cnt = 0; t = 0; t_eof1 = -1; pt = -1; px = -1; py = -1; pulses = 0;
        for (int f = 0; f < 3; f++) begin
            for (int v = 0; v < 4; v++) begin
                for (int h = 0; h < 8; h++) begin
                    m = (f == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    if (f == 0) begin
                        xs += h;
                        ys += v;
                        cnt++;
                    end
                    val2 = 1'b1; mask2 = m; hc2 = 11'(h); vc2 = 10'(v);
                    @(posedge clk_in);
                    #1;
                    t++;
                    if (valid2 && pulses == 0) begin
                        pt = t; px = x2; py = y2;
                    end
                    if (valid2) pulses++;
                    if (h == 7 && v == 3 && f == 0) begin
                        t_eof1 = t;
                        n_cmp++;
                        if (drop2 !== 1'b0) begin
                            n_fail++;
                            $display("FAIL dropped early: got %0b expected 0", drop2);
                        end
                    end
                    if (h == 7 && v == 3 && f == 1) begin
                        n_cmp++;
                        if (drop2 !== 1'b1) begin
                            n_fail++;
                            $display("FAIL dropped set: got %0b expected 1", drop2);
                        end
                    end
                end
            end
        end
        val2 = 1'b0;
        mask2 = 1'b0;
        repeat (80) @(posedge clk_in);
        #1;
        n_cmp++;
        if (drop2 !== 1'b1) begin
            n_fail++;
            $display("FAIL dropped sticky: got %0b expected 1", drop2);
        end
        n_cmp++;
        if (pt - t_eof1 != LATENCY) begin
            n_fail++;
            $display("FAIL dropped first_latency: got %0d expected %0d", pt - t_eof1, LATENCY);
        end
        n_cmp++;
        if (px != int'(xs / cnt) || py != int'(ys / cnt)) begin
            n_fail++;
            $display("FAIL dropped first_xy: got (%0d,%0d) expected (%0d,%0d)", px, py, xs / cnt, ys / cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_crosshair();
        test_below_threshold();
        test_last_pixel();
        test_random_frames();
        test_reset_mid();
        test_dropped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
